// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// legal WIDTH range and small helpers used by the top and the next-state logic.
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_JOHL = 3'b101;
    localparam logic [2:0] MODE_JOHR = 3'b110;
    localparam logic [2:0] MODE_ASR  = 3'b111;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // True when a WIDTH value lies inside the supported range.
    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    // Left-moving modes present the MSB on the serial output.
    function automatic bit mode_is_left(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_ROL) || (m == MODE_JOHL);
    endfunction

endpackage

// File: rtl/univ_shift_next.sv
// Purely combinational next-value map (q, mode, si) -> q_next, shared by the
// single-step and burst paths of univ_shift_reg.
module univ_shift_next
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             si,
    output logic [WIDTH-1:0] q_next
);

    // One shift/rotate/counter step in the selected mode.
    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_SHL:  q_next = {q[WIDTH-2:0], si};
            MODE_SHR:  q_next = {si, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_JOHL: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
            MODE_JOHR: q_next = {~q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register top: parallel load, single-step shifting and,
// when UNIV_SHIFT_BURST_EN is defined, a self-timed WIDTH-step burst.
// Without UNIV_SHIFT_BURST_EN, start is ignored and busy/done stay 0.
//
// Burst handshake: start is a one-cycle request honoured only while busy=0
// and ld=0; busy=1 means further start/en/mode are ignored; done pulses for
// one cycle after the final step, and start may be asserted in that cycle.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       mode,
    input  logic             en,
    input  logic             si,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam bit WIDTH_OK = width_legal(WIDTH);

    if (!WIDTH_OK) begin : g_bad_width
        $error("univ_shift_reg: WIDTH out of range 2..32");
    end

    logic [2:0]       active_mode;
    logic [WIDTH-1:0] q_next;

    univ_shift_next #(.WIDTH(WIDTH)) u_next (
        .q      (q),
        .mode   (active_mode),
        .si     (si),
        .q_next (q_next)
    );

    // Serial output follows the end of the register the active mode shifts out of.
    assign so = mode_is_left(active_mode) ? q[WIDTH-1] : q[0];

`ifdef UNIV_SHIFT_BURST_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;
    logic [2:0]    burst_mode;
    logic          busy_r;
    logic          done_r;

    assign active_mode = busy_r ? burst_mode : mode;
    assign busy        = busy_r;
    assign done        = done_r;

    // Register and burst control; priority is ld, then a running burst, then start, then en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            cnt        <= '0;
            burst_mode <= MODE_HOLD;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (ld) begin
                // Load also aborts a running burst silently.
                q      <= d;
                cnt    <= '0;
                busy_r <= 1'b0;
            end else if (busy_r) begin
                q   <= q_next;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end else if (start) begin
                // Arm only: the first burst step happens on the next edge.
                burst_mode <= mode;
                cnt        <= CW'(WIDTH);
                busy_r     <= 1'b1;
            end else if (en) begin
                q <= q_next;
            end
        end
    end
`else
    logic unused_start;

    assign unused_start = start;
    assign active_mode  = mode;
    assign busy         = 1'b0;
    assign done         = 1'b0;

    // Register: parallel load has priority over a single step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= q_next;
        end
    end
`endif

endmodule
